// File: rtl/cube_pkg.sv
// Shared constants for the cube-solver register file: colour bitplanes,
// the solved-cube reset image and the snapshot controller state encoding.
package cube_pkg;

  localparam logic [23:0] BLUE         = 24'h8000C1;
  localparam logic [23:0] WHITE        = 24'h081408;
  localparam logic [23:0] RED          = 24'h132000;
  localparam logic [23:0] IDEAL_0      = BLUE;
  localparam logic [23:0] IDEAL_1      = WHITE;
  localparam logic [23:0] IDEAL_2      = RED;
  localparam logic [23:0] IDEAL_CENTRE = 24'hF00000;

  // Word 0 sits in the least significant slice; register 9 holds the centre mask.
  localparam logic [16*24-1:0] RF_INIT = {
    {6{24'h000000}}, IDEAL_CENTRE, {6{24'h000000}}, IDEAL_2, IDEAL_1, IDEAL_0
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PUSH = 2'd1,
    ST_POP  = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snap_stack.sv
// Snapshot storage: STACK_DEPTH frames of SNAP_REGS words, one write port and
// one combinational read port, both addressed by {frame, word}.
module snap_stack
  import cube_pkg::*;
#(
  parameter int WIDTH       = 24,
  parameter int SNAP_REGS   = 3,
  parameter int STACK_DEPTH = 8
) (
  input  logic                                    clk,
  input  logic                                    wr_en,
  input  logic [clog2_min1(STACK_DEPTH)-1:0]      wr_lvl,
  input  logic [clog2_min1(SNAP_REGS)-1:0]        wr_idx,
  input  logic [WIDTH-1:0]                        wr_data,
  input  logic [clog2_min1(STACK_DEPTH)-1:0]      rd_lvl,
  input  logic [clog2_min1(SNAP_REGS)-1:0]        rd_idx,
  output logic [WIDTH-1:0]                        rd_data
);

  localparam int N  = STACK_DEPTH * SNAP_REGS;
  localparam int MW = clog2_min1(N);

  logic [WIDTH-1:0] mem [N];
  logic [MW-1:0]    waddr;
  logic [MW-1:0]    raddr;

  assign waddr   = MW'(int'(wr_lvl) * SNAP_REGS + int'(wr_idx));
  assign raddr   = MW'(int'(rd_lvl) * SNAP_REGS + int'(rd_idx));
  assign rd_data = mem[raddr];

  // Frame contents are only meaningful below the stack level, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[waddr] <= wr_data;
  end

endmodule

// File: rtl/cube_regfile.sv
// Cube-state register file with two async read ports, one write port and a
// snapshot stack that checkpoints/restores a contiguous register group.
module cube_regfile
  import cube_pkg::*;
#(
  parameter int                       WIDTH       = 24,
  parameter int                       DEPTH       = 16,
  parameter logic [DEPTH*WIDTH-1:0]   INIT        = RF_INIT,
  parameter int                       SNAP_BASE   = 0,
  parameter int                       SNAP_REGS   = 3,
  parameter int                       STACK_DEPTH = 8,
  parameter bit                       BYPASS      = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [$clog2(DEPTH)-1:0]           src0,
  input  logic [$clog2(DEPTH)-1:0]           src1,
  output logic [WIDTH-1:0]                   data0,
  output logic [WIDTH-1:0]                   data1,
  input  logic                               we,
  input  logic [$clog2(DEPTH)-1:0]           dst,
  input  logic [WIDTH-1:0]                   data,
  input  logic                               push,
  input  logic                               pop,
  input  logic                               clr_err,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
  output logic                               full,
  output logic                               empty,
  output logic                               err_ovf,
  output logic                               err_unf,
  output logic                               err_wr
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STACK_DEPTH + 1);
  localparam int LW = clog2_min1(STACK_DEPTH);
  localparam int KW = clog2_min1(SNAP_REGS);
  localparam logic [KW-1:0] K_LAST = KW'(SNAP_REGS - 1);

  logic [WIDTH-1:0] rf [DEPTH];
  state_t           st;
  state_t           nxt;
  logic [KW-1:0]    k;
  logic             last;
  logic             set_ovf;
  logic             set_unf;
  logic [AW-1:0]    sidx;
  logic             stk_we;
  logic [WIDTH-1:0] stk_rd;

  function automatic logic in_rng(input logic [AW-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  assign busy  = (st != ST_IDLE);
  assign full  = (level == SW'(STACK_DEPTH));
  assign empty = (level == '0);
  assign sidx  = AW'(SNAP_BASE) + AW'(k);
  assign stk_we = (st == ST_PUSH);

  always_comb begin
    nxt     = st;
    last    = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    unique case (st)
      ST_IDLE: begin
        // Simultaneous push and pop cancel out without flagging anything.
        if (push && !pop) begin
          if (full) set_ovf = 1'b1;
          else      nxt = ST_PUSH;
        end else if (pop && !push) begin
          if (empty) set_unf = 1'b1;
          else       nxt = ST_POP;
        end
      end
      ST_PUSH, ST_POP: begin
        if (k == K_LAST) begin
          last = 1'b1;
          nxt  = ST_IDLE;
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) st <= ST_IDLE;
    else     st <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      level   <= '0;
      done    <= 1'b0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
      err_wr  <= 1'b0;
    end else begin
      k    <= (busy && !last) ? k + 1'b1 : '0;
      done <= last;
      if (last) level <= (st == ST_PUSH) ? level + 1'b1 : level - 1'b1;
      // Clear first so a same-cycle error condition leaves the flag set.
      if (clr_err) begin
        err_ovf <= 1'b0;
        err_unf <= 1'b0;
        err_wr  <= 1'b0;
      end
      if (set_ovf)     err_ovf <= 1'b1;
      if (set_unf)     err_unf <= 1'b1;
      if (busy && we)  err_wr  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= INIT[i*WIDTH +: WIDTH];
    end else if (st == ST_POP) begin
      rf[sidx] <= stk_rd;
    end else if (st == ST_IDLE && we && in_rng(dst)) begin
      rf[dst] <= data;
    end
  end

  always_comb begin
    data0 = '0;
    data1 = '0;
    if (in_rng(src0)) data0 = rf[src0];
    if (in_rng(src1)) data1 = rf[src1];
    if (BYPASS && st == ST_IDLE && we && in_rng(dst)) begin
      if (dst == src0) data0 = data;
      if (dst == src1) data1 = data;
    end
  end

  snap_stack #(
    .WIDTH       (WIDTH),
    .SNAP_REGS   (SNAP_REGS),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .wr_en   (stk_we),
    .wr_lvl  (LW'(level)),
    .wr_idx  (k),
    .wr_data (rf[sidx]),
    .rd_lvl  (LW'(level - 1'b1)),
    .rd_idx  (k),
    .rd_data (stk_rd)
  );

endmodule
